// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_sequencer slice: opcode and ULA select
// constants, the sequencer state type, the decoded-instruction record and
// default widths.
package cpu_pkg;

  localparam int OPW_DEF          = 3;
  localparam int ULAW_DEF         = 2;
  localparam int MULT_TIMEOUT_DEF = 16;

  localparam logic [OPW_DEF-1:0] OP_NOP  = 3'b000;
  localparam logic [OPW_DEF-1:0] OP_STOP = 3'b001;
  localparam logic [OPW_DEF-1:0] OP_LOAD = 3'b010;
  localparam logic [OPW_DEF-1:0] OP_SET  = 3'b011;
  localparam logic [OPW_DEF-1:0] OP_ADD  = 3'b100;
  localparam logic [OPW_DEF-1:0] OP_MULT = 3'b101;

  localparam logic [ULAW_DEF-1:0] ULA_PASS = 2'd0;
  localparam logic [ULAW_DEF-1:0] ULA_LOAD = 2'd1;
  localparam logic [ULAW_DEF-1:0] ULA_ADD  = 2'd2;
  localparam logic [ULAW_DEF-1:0] ULA_MULT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MWAIT,
    S_HALT
  } seq_state_t;

  // What the execute phase has to do for the captured opcode.
  typedef struct packed {
    logic                rd;
    logic                wr;
    logic                acc;
    logic                mult;
    logic                stop;
    logic                trap;
    logic [ULAW_DEF-1:0] ula;
  } dec_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath/memory
// side (slave): handshake inputs and strobe outputs.
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int OPW  = OPW_DEF,
  parameter int ULAW = ULAW_DEF
);

  logic            start;
  logic [OPW-1:0]  opcode;
  logic            mem_ack;
  logic            mult_done;
  logic            mem_rd;
  logic            mem_wr;
  logic            ir_ld;
  logic            pc_inc;
  logic            acc_ld;
  logic [ULAW-1:0] ula_op;
  logic            mult_start;
  logic            halted;
  logic            err;

  modport master (
    input  start, opcode, mem_ack, mult_done,
    output mem_rd, mem_wr, ir_ld, pc_inc, acc_ld, ula_op, mult_start,
           halted, err
  );

  modport slave (
    output start, opcode, mem_ack, mult_done,
    input  mem_rd, mem_wr, ir_ld, pc_inc, acc_ld, ula_op, mult_start,
           halted, err
  );

endinterface

// File: rtl/cpu_sequencer_dec.sv
// Instruction decoder: turns the captured opcode into the execute-phase
// actions and the ULA select used on the accumulator load.
// Build option: SEQ_ILLEGAL_TRAP_EN makes opcodes 110/111 trap to HALT
// with err set; otherwise they execute as NOP.
module cpu_sequencer_dec
  import cpu_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [OPW-1:0] i_op,
  output dec_t           o_dec
);

  // Pure table lookup; unknown opcodes fall to the illegal handling.
  always_comb begin
    o_dec     = '0;
    o_dec.ula = ULA_PASS;
    case (i_op)
      OPW'(OP_NOP):  ;
      OPW'(OP_STOP): o_dec.stop = 1'b1;
      OPW'(OP_LOAD): begin
        o_dec.rd  = 1'b1;
        o_dec.acc = 1'b1;
        o_dec.ula = ULA_LOAD;
      end
      OPW'(OP_SET):  o_dec.wr = 1'b1;
      OPW'(OP_ADD):  begin
        o_dec.rd  = 1'b1;
        o_dec.acc = 1'b1;
        o_dec.ula = ULA_ADD;
      end
      OPW'(OP_MULT): begin
        o_dec.rd   = 1'b1;
        o_dec.mult = 1'b1;
      end
      default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
        o_dec.trap = 1'b1;
`else
        o_dec.trap = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/seq_timeout_cnt.sv
// Loadable up-counter that flags the last cycle the sequencer may wait
// for the multiplier before declaring a timeout.
module seq_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam int CW = $clog2(LIMIT);

  logic [CW-1:0] r_cnt;

  // Clear has priority so a fresh wait always starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_term = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the simple computer.
// All strobes are decoded combinationally from the state, the captured
// opcode and the ack/done inputs; only err is registered.
// Build option: SEQ_ILLEGAL_TRAP_EN (see cpu_sequencer_dec).
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW          = OPW_DEF,
  parameter int ULAW         = ULAW_DEF,
  parameter int MULT_TIMEOUT = MULT_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_sequencer_if.master  bus
);

  seq_state_t     r_state;
  seq_state_t     w_next;
  logic [OPW-1:0] r_op_q;
  logic           r_err;
  logic           w_err_set;
  logic           w_err_clr;
  logic           w_cnt_clr;
  logic           w_cnt_en;
  logic           w_term;
  dec_t           w_dec;

  cpu_sequencer_dec #(.OPW(OPW)) u_dec (
    .i_op  (r_op_q),
    .o_dec (w_dec)
  );

  seq_timeout_cnt #(.LIMIT(MULT_TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_term (w_term)
  );

  // State register, opcode capture in DECODE and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_q  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op_q <= bus.opcode;
      end
      if (w_err_clr) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;

  // Next state and strobes; a done on the timeout cycle wins over the error.
  always_comb begin
    w_next         = r_state;
    w_err_set      = 1'b0;
    w_err_clr      = 1'b0;
    w_cnt_clr      = 1'b0;
    w_cnt_en       = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ir_ld      = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.acc_ld     = 1'b0;
    bus.ula_op     = '0;
    bus.mult_start = 1'b0;
    bus.halted     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_ld  = 1'b1;
          bus.pc_inc = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_dec.stop) begin
          w_next = S_HALT;
        end else if (w_dec.trap) begin
          w_err_set = 1'b1;
          w_next    = S_HALT;
        end else if (w_dec.rd) begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ack) begin
            if (w_dec.mult) begin
              bus.mult_start = 1'b1;
              w_cnt_clr      = 1'b1;
              w_next         = S_MWAIT;
            end else begin
              bus.acc_ld = w_dec.acc;
              bus.ula_op = w_dec.acc ? ULAW'(w_dec.ula) : '0;
              w_next     = S_FETCH;
            end
          end
        end else if (w_dec.wr) begin
          bus.mem_wr = 1'b1;
          if (bus.mem_ack) w_next = S_FETCH;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MWAIT: begin
        w_cnt_en = 1'b1;
        if (bus.mult_done) begin
          bus.acc_ld = 1'b1;
          bus.ula_op = ULAW'(ULA_MULT);
          w_next     = S_FETCH;
        end else if (w_term) begin
          w_err_set = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_HALT: begin
        bus.halted = 1'b1;
        if (bus.start) begin
          w_err_clr = 1'b1;
          w_next    = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: acts as memory/multiplier,
// runs directed and random instruction streams and compares every
// cycle's strobes with what the instruction semantics call for.
module tb_cpu_sequencer;

  localparam int TMO = 4;

  // Observed vector layout: rd wr irld pcinc acc ula[1:0] mstart halted err
  localparam logic [9:0] RD    = 10'b1000000000;
  localparam logic [9:0] WR    = 10'b0100000000;
  localparam logic [9:0] IRLD  = 10'b0010000000;
  localparam logic [9:0] PCINC = 10'b0001000000;
  localparam logic [9:0] ACC   = 10'b0000100000;
  localparam logic [9:0] ULA1  = 10'b0000001000;
  localparam logic [9:0] ULA2  = 10'b0000010000;
  localparam logic [9:0] ULA3  = 10'b0000011000;
  localparam logic [9:0] MS    = 10'b0000000100;
  localparam logic [9:0] HLT   = 10'b0000000010;
  localparam logic [9:0] NONE  = 10'b0000000000;

  logic clk;
  logic rst_n;
  int   total      = 0;
  int   bad        = 0;
  int   fetchCount = 0;
  int   pcIncSeen  = 0;
  logic modelErr   = 1'b0;
  logic [9:0] obs;
  bit   h;

  cpu_sequencer_if #(.OPW(3), .ULAW(2)) bus ();

  cpu_sequencer #(.OPW(3), .ULAW(2), .MULT_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign obs = {bus.mem_rd, bus.mem_wr, bus.ir_ld, bus.pc_inc, bus.acc_ld,
                bus.ula_op, bus.mult_start, bus.halted, bus.err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count program-counter increments independently of the per-cycle checks.
  always @(negedge clk) begin
    if (bus.pc_inc === 1'b1) pcIncSeen++;
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, check strobes mid-cycle, advance past the edge.
  task automatic applyStimulus(input string tag, input logic st, input logic ack,
                               input logic dn, input logic [9:0] exp);
    bus.start     = st;
    bus.mem_ack   = ack;
    bus.mult_done = dn;
    @(negedge clk);
    checkOutput(tag, {6'b0, obs}, {6'b0, exp[9:1], modelErr});
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH onward; reports whether it ends in HALT.
  task automatic runInstr(input logic [2:0] op, input int w, input int md,
                          output bit goHalt);
    bit fin;
    fin    = 1'b0;
    goHalt = 1'b0;
    for (int i = 0; i < w; i++) applyStimulus("fetch_wait", rb(), 1'b0, rb(), RD);
    applyStimulus("fetch_ack", rb(), 1'b1, rb(), RD | IRLD | PCINC);
    fetchCount++;
    bus.opcode = op;
    applyStimulus("decode", rb(), rb(), rb(), NONE);
    bus.opcode = 3'($urandom);
    case (op)
      3'd0: applyStimulus("exec_nop", rb(), rb(), rb(), NONE);
      3'd1: begin
        applyStimulus("exec_stop", rb(), rb(), rb(), NONE);
        goHalt = 1'b1;
      end
      3'd2, 3'd4: begin
        for (int i = 0; i < w; i++) applyStimulus("opnd_wait", rb(), 1'b0, rb(), RD);
        applyStimulus(op == 3'd2 ? "load_ack" : "add_ack", rb(), 1'b1, rb(),
                      RD | ACC | (op == 3'd2 ? ULA1 : ULA2));
      end
      3'd3: begin
        for (int i = 0; i < w; i++) applyStimulus("set_wait", rb(), 1'b0, rb(), WR);
        applyStimulus("set_ack", rb(), 1'b1, rb(), WR);
      end
      3'd5: begin
        for (int i = 0; i < w; i++) applyStimulus("mult_opnd_wait", rb(), 1'b0, rb(), RD);
        applyStimulus("mult_opnd_ack", rb(), 1'b1, rb(), RD | MS);
        for (int c = 1; c <= TMO && !fin; c++) begin
          if (c == md) begin
            applyStimulus("mult_done", rb(), rb(), 1'b1, ACC | ULA3);
            fin = 1'b1;
          end else begin
            applyStimulus("mwait", rb(), rb(), 1'b0, NONE);
            if (c == TMO) begin
              modelErr = 1'b1;
              goHalt   = 1'b1;
            end
          end
        end
      end
      default: begin
        applyStimulus("exec_illegal", rb(), rb(), rb(), NONE);
`ifdef SEQ_ILLEGAL_TRAP_EN
        modelErr = 1'b1;
        goHalt   = 1'b1;
`endif
      end
    endcase
  endtask

  // Sit in HALT for n cycles, then restart; err clears on the restart edge.
  task automatic resumeFromHalt(input int n);
    for (int i = 0; i < n; i++) applyStimulus("halt", 1'b0, rb(), rb(), HLT);
    applyStimulus("halt_start", 1'b1, rb(), rb(), HLT);
    modelErr = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.opcode    = '0;
    bus.mem_ack   = 1'b0;
    bus.mult_done = 1'b0;
    #3;
    checkOutput("reset_outputs", {6'b0, obs}, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus("idle", 1'b0, rb(), rb(), NONE);
    applyStimulus("idle", 1'b0, rb(), rb(), NONE);
    applyStimulus("idle_start", 1'b1, rb(), rb(), NONE);

    // Directed program covering each opcode and the timeout boundary.
    runInstr(3'd0, 2, 0, h);
    runInstr(3'd2, 2, 0, h);
    runInstr(3'd3, 2, 0, h);
    runInstr(3'd4, 1, 0, h);
    runInstr(3'd5, 1, TMO, h);
    runInstr(3'd5, 0, 3, h);
    runInstr(3'd5, 0, 0, h);
    if (h) resumeFromHalt(2);
    runInstr(3'd1, 1, 0, h);
    if (h) resumeFromHalt(10);
    runInstr(3'd7, 0, 0, h);
    if (h) resumeFromHalt(1);

    // Reset in the middle of a fetch drops the read request at once.
    applyStimulus("fetch_wait", rb(), 1'b0, rb(), RD);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {6'b0, obs}, 16'h0);
    modelErr = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus("idle", 1'b0, rb(), rb(), NONE);
    applyStimulus("idle_start", 1'b1, rb(), rb(), NONE);

    // Random instruction stream with random memory and multiplier latency.
    for (int k = 0; k < 60; k++) begin
      runInstr(3'($urandom_range(0, 7)), $urandom_range(0, 3),
               $urandom_range(0, TMO), h);
      if (h) resumeFromHalt($urandom_range(0, 3));
    end

    checkOutput("pc_inc_count", 16'(pcIncSeen), 16'(fetchCount));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
